// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core. It merges the per-stage stall requests into
// the stall bus. It sequences exception flushes and delays the PC redirect until any
// in-flight fetch has completed. It also counts stalled cycles in a saturating counter.
module pipe_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [PC_W-1:0]  excp_target,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [PC_W-1:0]  new_pc,
    output logic             new_pc_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {StIdle, StWaitIf} state_e;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallIf   = 6'b000011;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallMem  = 6'b011111;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [PC_W-1:0]  new_pc_q, new_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       stall_enc, stall_d;
    logic             flush_d, valid_d;

    // Stall priority encoder: the furthest-downstream requester wins.
    always_comb begin
        stall_enc = StallNone;
        if (stallreq_mem)     stall_enc = StallMem;
        else if (stallreq_ex) stall_enc = StallEx;
        else if (stallreq_id) stall_enc = StallId;
        else if (stallreq_if) stall_enc = StallIf;
    end

    // Flush/redirect sequencing and next-state logic.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        stall_d  = stall_enc;
        flush_d  = 1'b0;
        valid_d  = 1'b0;
        new_pc_d = new_pc_q;
        unique case (state_q)
            StIdle: begin
                if (excp_valid) begin
                    flush_d = 1'b1;
                    if (!stallreq_if) begin
                        valid_d  = 1'b1;
                        new_pc_d = excp_target;
                        stall_d  = StallNone;
                    end else begin
                        // Fetch still in flight: hold PC/IF and redirect once it lands.
                        stall_d  = StallIf;
                        target_d = excp_target;
                        state_d  = StWaitIf;
                    end
                end
            end
            StWaitIf: begin
                // Downstream is already flushed, so its stall requests are ignored.
                stall_d = StallIf;
                if (excp_valid) begin
                    flush_d  = 1'b1;
                    target_d = excp_target;
                end
                if (!stallreq_if) begin
                    valid_d  = 1'b1;
                    new_pc_d = excp_valid ? excp_target : target_q;
                    stall_d  = StallNone;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating stall-cycle counter, keyed on the IF/ID stall bit.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_d[2] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            target_q <= '0;
            new_pc_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            new_pc_q <= new_pc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        stall        = rst ? stall_d : 6'b0;
        flush        = rst & flush_d;
        new_pc_valid = rst & valid_d;
        new_pc       = rst ? new_pc_d : '0;
        stall_cnt    = cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. A second instance with a 4-bit counter exercises
// counter saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_target;

    logic [5:0]  stall, s_stall;
    logic        flush, s_flush;
    logic [31:0] new_pc, s_new_pc;
    logic        new_pc_valid, s_new_pc_valid;
    logic [31:0] stall_cnt;
    logic [3:0]  s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(.PC_W(32), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_target(excp_target),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .new_pc_valid(new_pc_valid), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.PC_W(32), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_target(excp_target),
        .stall(s_stall), .flush(s_flush), .new_pc(s_new_pc),
        .new_pc_valid(s_new_pc_valid), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                         input logic ev, input logic [31:0] tgt);
        stallreq_if  = i_if;
        stallreq_id  = i_id;
        stallreq_ex  = i_ex;
        stallreq_mem = i_mem;
        excp_valid   = ev;
        excp_target  = tgt;
        #2;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hdead_beef);
        check("rst_stall", stall, 6'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_npv", new_pc_valid, 1'b0);
        check("rst_newpc", new_pc, 32'h0);
        cyc();
        rst = 1'b1;

        // Idle for 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check("idle_stall", stall, 6'b0);
            check("idle_flush", flush, 1'b0);
            check("idle_npv", new_pc_valid, 1'b0);
            cyc();
        end
        check("idle_cnt", stall_cnt, 32'd0);

        // Requests from id and ex together: ex wins
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check("idex_stall", stall, 6'b001111);
            cyc();
        end
        check("idex_cnt", stall_cnt, 32'd3);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("all_stall", stall, 6'b011111);
        cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("nomem_stall", stall, 6'b001111);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("id_stall", stall, 6'b000111);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("if_stall", stall, 6'b000011);
        check("cnt5", stall_cnt, 32'd5);

        // Immediate redirect: stall requests are overridden
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBFC0_0380);
        check("imm_flush", flush, 1'b1);
        check("imm_npv", new_pc_valid, 1'b1);
        check("imm_newpc", new_pc, 32'hBFC0_0380);
        check("imm_stall", stall, 6'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111_1111);
        check("imm_after_flush", flush, 1'b0);
        check("imm_after_npv", new_pc_valid, 1'b0);
        check("imm_hold_newpc", new_pc, 32'hBFC0_0380);
        check("imm_cnt", stall_cnt, 32'd5);
        cyc();

        // Deferred redirect while the fetch is in flight, with a second exception
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0180);
        check("d0_flush", flush, 1'b1);
        check("d0_npv", new_pc_valid, 1'b0);
        check("d0_stall", stall, 6'b000011);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("d1_flush", flush, 1'b0);
        check("d1_stall", stall, 6'b000011);
        check("d1_newpc_hold", new_pc, 32'hBFC0_0380);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0200);
        check("d2_flush", flush, 1'b1);
        check("d2_stall", stall, 6'b000011);
        check("d2_npv", new_pc_valid, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("d3_stall", stall, 6'b000011);
        check("d3_flush", flush, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("d4_npv", new_pc_valid, 1'b1);
        check("d4_newpc", new_pc, 32'h8000_0200);
        check("d4_stall", stall, 6'b0);
        check("d4_flush", flush, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("d5_npv", new_pc_valid, 1'b0);
        check("d5_idle_stall", stall, 6'b000111);
        check("d_cnt", stall_cnt, 32'd5);
        cyc();

        // Exception coincides with the fetch completing: the fresh target wins
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        check("co_npv", new_pc_valid, 1'b1);
        check("co_newpc", new_pc, 32'h1234_5678);
        check("co_flush", flush, 1'b1);
        check("co_stall", stall, 6'b0);
        cyc();
        check("co_cnt", stall_cnt, 32'd6);
        check("co_small_cnt", s_stall_cnt, 4'd6);

        // Hold id for 20 cycles: the 4-bit counter saturates
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            cyc();
        end
        check("sat_cnt32", stall_cnt, 32'd26);
        check("sat_cnt4", s_stall_cnt, 4'd15);

        // Reset in the middle of WAIT_IF discards the pending redirect
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0000);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("w_stall", stall, 6'b000011);
        rst = 1'b0;
        #1;
        check("ar_stall", stall, 6'b0);
        check("ar_flush", flush, 1'b0);
        check("ar_newpc", new_pc, 32'h0);
        check("ar_npv", new_pc_valid, 1'b0);
        check("ar_cnt", stall_cnt, 32'd0);
        check("ar_small_cnt", s_stall_cnt, 4'd0);
        cyc();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("post_npv", new_pc_valid, 1'b0);
        check("post_stall", stall, 6'b0);
        check("post_newpc", new_pc, 32'h0);
        cyc();
        check("post_npv2", new_pc_valid, 1'b0);
        check("post_small_npv", s_new_pc_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
